sfifo_wr_arbiter: RTL

Write-side arbiter and sequencer for one SFIFO_36K_BLK synchronous FIFO. It lets NUM_REQ independent producers share the FIFO's PUSH/DIN port using round-robin, burst-locked grants. It also sequences Async_Flush on request, holding off all writers while the flush runs. It sits between the producer logic and the FIFO primitive, in the same clock domain.

---
 rtl/sfifo_wr_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin, burst-locked write arbiter and Async_Flush sequencer for one SFIFO_36K_BLK.
// Define SFIFO_WR_ARB_OVERRUN_CNT_EN to build the saturating overrun_count; otherwise it is tied to 0.
module sfifo_wr_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 36,
    parameter int BURST_MAX    = 16,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          flush_req,
    output logic                          flush_busy,
    output logic                          PUSH,
    output logic [DATA_WIDTH-1:0]         DIN,
    output logic                          Async_Flush,
    input  logic                          Full,
    input  logic                          Almost_Full,
    input  logic                          Overrun_Error,
    output logic [1:0]                    grant_id,
    output logic [15:0]                   overrun_count
);

    typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [1:0]              r_ptr;
    logic [1:0]              r_grant_id;
    logic [7:0]              r_beat_cnt;
    logic [3:0]              r_fcnt;
    logic                    r_flush_pend;
    logic                    r_flush_q;
    logic                    r_push;
    logic [DATA_WIDTH-1:0]   r_din;
    logic                    r_async_flush;
    logic                    r_flush_busy;

    logic                    w_arb_any;
    logic [1:0]              w_arb_idx;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_accept;
    logic                    w_accept_last;
    logic                    w_burst_done;
    logic                    w_flush_evt;
    logic                    w_fcnt_done;

    // Only a 0->1 edge of flush_req starts a flush, so a level held past the flush cannot retrigger it.
    assign w_flush_evt   = flush_req & ~r_flush_q & (r_state != FLUSH);
    assign w_fcnt_done   = (r_fcnt == 4'(FLUSH_CYCLES));
    assign w_accept      = |(req_valid & req_ready);
    assign w_accept_last = |(req_valid & req_ready & req_last);
    assign w_burst_done  = w_accept & (w_accept_last | ((r_beat_cnt + 8'd1) == 8'(BURST_MAX)));

    always_comb begin
        int v_best;
        int v_dist;
        v_best    = NUM_REQ;
        v_dist    = 0;
        w_arb_any = 1'b0;
        w_arb_idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_dist = (i + 2 * NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ;
            if (req_valid[i] && (v_dist < v_best)) begin
                v_best    = v_dist;
                w_arb_any = 1'b1;
                w_arb_idx = 2'(i);
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == 2'(i)) w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_flush_evt || r_flush_pend) w_next_state = FLUSH;
                else if (w_arb_any)              w_next_state = GRANT;
            end
            GRANT:   if (w_burst_done) w_next_state = IDLE;
            FLUSH:   if (w_fcnt_done)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if ((r_state == GRANT) && !Almost_Full && !Full) begin
            for (int i = 0; i < NUM_REQ; i++) req_ready[i] = (r_grant_id == 2'(i));
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ptr         <= 2'(NUM_REQ - 1);
            r_grant_id    <= 2'd0;
            r_beat_cnt    <= 8'd0;
            r_fcnt        <= 4'd0;
            r_flush_pend  <= 1'b0;
            r_flush_q     <= 1'b0;
            r_push        <= 1'b0;
            r_din         <= '0;
            r_async_flush <= 1'b0;
            r_flush_busy  <= 1'b0;
        end else begin
            r_flush_q     <= flush_req;
            r_push        <= w_accept;
            r_async_flush <= (r_state == FLUSH) && !w_fcnt_done;
            r_flush_busy  <= w_flush_evt | r_flush_pend | (r_state == FLUSH);
            if (w_accept) r_din <= w_sel_data;
            case (r_state)
                IDLE: begin
                    if (w_next_state == GRANT) begin
                        r_grant_id <= w_arb_idx;
                        r_beat_cnt <= 8'd0;
                    end
                end
                GRANT: begin
                    if (w_accept)     r_beat_cnt   <= r_beat_cnt + 8'd1;
                    if (w_burst_done) r_ptr        <= r_grant_id;
                    if (w_flush_evt)  r_flush_pend <= 1'b1;
                end
                FLUSH: begin
                    r_fcnt <= w_fcnt_done ? 4'd0 : r_fcnt + 4'd1;
                    if (w_fcnt_done) r_flush_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign PUSH        = r_push;
    assign DIN         = r_din;
    assign Async_Flush = r_async_flush;
    assign flush_busy  = r_flush_busy;
    assign grant_id    = r_grant_id;

`ifdef SFIFO_WR_ARB_OVERRUN_CNT_EN
    logic [15:0] r_overrun_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                                    r_overrun_cnt <= 16'd0;
        else if (r_async_flush)                          r_overrun_cnt <= 16'd0;
        else if (Overrun_Error && r_overrun_cnt != 16'hFFFF) r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end

    assign overrun_count = r_overrun_cnt;
`else
    logic w_unused_overrun;
    assign w_unused_overrun = Overrun_Error;
    assign overrun_count    = 16'd0;
`endif

endmodule
